// File: rtl/lfsr_pkg.sv
// Constants and types shared by the 8-bit LFSR generator and its downstream checker.
package lfsr_pkg;

    localparam int unsigned        LFSR_W     = 8;
    localparam logic [LFSR_W-1:0]  DEF_TAPS   = 8'hB8;
    localparam bit                 DEF_INVERT = 1'b1;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } chk_state_e;

    // XNOR feedback gets stuck at all-ones, XOR feedback at all-zeros.
    function automatic logic [LFSR_W-1:0] lockup_word(input bit invert);
        return invert ? {LFSR_W{1'b1}} : {LFSR_W{1'b0}};
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-word predictor: applies the generator recurrence to the last two words seen.
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int unsigned    W        = LFSR_W,
    parameter logic [W-1:0]   TAPS     = DEF_TAPS,
    parameter bit             INVERT   = DEF_INVERT,
    parameter bit             FB_DELAY = 1'b1
) (
    input  logic [W-1:0] h0,
    input  logic [W-1:0] h1,
    output logic [W-1:0] expected
);

    logic [W-1:0] src;
    logic         fb;

    // A registered-feedback generator builds its new bit from the word one step older.
    assign src      = FB_DELAY ? h1 : h0;
    assign fb       = (^(src & TAPS)) ^ INVERT;
    assign expected = {h0[W-2:0], fb};

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: predicts each generator word, locks after a run of matches, counts errors
// while locked and measures the sequence period between recurrences of the lock word.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned    W        = LFSR_W,
    parameter logic [W-1:0]   TAPS     = DEF_TAPS,
    parameter bit             INVERT   = DEF_INVERT,
    parameter bit             FB_DELAY = 1'b1,
    parameter int unsigned    LOCK_CNT = 4,
    parameter int unsigned    LOSS_CNT = 3,
    parameter int unsigned    CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [W-1:0]  i_data,
    input  logic          i_clr,
    output logic          o_locked,
    output logic          o_err,
    output logic [CW-1:0] o_err_cnt,
    output logic [CW-1:0] o_word_cnt,
    output logic [CW-1:0] o_period,
    output logic          o_period_vld
);

    localparam logic [W-1:0]  LOCKUP  = {W{INVERT}};
    localparam logic [3:0]    LOCK_N  = 4'(LOCK_CNT);
    localparam logic [3:0]    LOSS_N  = 4'(LOSS_CNT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    chk_state_e    state, state_nx;
    logic [3:0]    run, run_nx, run_step;
    logic [3:0]    miss, miss_nx;
    logic [W-1:0]  h0, h1, expected, ref_word;
    logic [1:0]    hist_n;
    logic [CW-1:0] pcnt;
    logic          pred_valid, match, lock_entry, lock_loss;

    lfsr_predict #(
        .W        (W),
        .TAPS     (TAPS),
        .INVERT   (INVERT),
        .FB_DELAY (FB_DELAY)
    ) u_predict (
        .h0       (h0),
        .h1       (h1),
        .expected (expected)
    );

    assign pred_valid = (hist_n > {1'b0, FB_DELAY});
    assign match      = pred_valid && (i_data == expected) && (i_data != LOCKUP);
    assign run_step   = (state == HUNT) ? 4'd1 : run + 4'd1;
    assign o_locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
            run   <= '0;
            miss  <= '0;
        end else begin
            state <= state_nx;
            run   <= run_nx;
            miss  <= miss_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        run_nx     = run;
        miss_nx    = miss;
        lock_entry = 1'b0;
        lock_loss  = 1'b0;
        if (i_valid) begin
            case (state)
                HUNT, VERIFY: begin
                    if (!match) begin
                        state_nx = HUNT;
                        run_nx   = '0;
                    end else if (run_step == LOCK_N) begin
                        state_nx   = LOCKED;
                        run_nx     = '0;
                        miss_nx    = '0;
                        lock_entry = 1'b1;
                    end else begin
                        state_nx = VERIFY;
                        run_nx   = run_step;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_nx = '0;
                    end else if (miss + 4'd1 == LOSS_N) begin
                        state_nx  = HUNT;
                        miss_nx   = '0;
                        lock_loss = 1'b1;
                    end else begin
                        miss_nx = miss + 4'd1;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // Clear only touches the reported results; an in-flight period measurement keeps running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h0           <= '0;
            h1           <= '0;
            hist_n       <= '0;
            ref_word     <= '0;
            pcnt         <= '0;
            o_err        <= 1'b0;
            o_err_cnt    <= '0;
            o_word_cnt   <= '0;
            o_period     <= '0;
            o_period_vld <= 1'b0;
        end else begin
            o_err        <= 1'b0;
            o_period_vld <= 1'b0;
            if (i_valid) begin
                h0 <= i_data;
                h1 <= h0;
                if (hist_n != 2'd2)
                    hist_n <= hist_n + 2'd1;
                if (lock_entry) begin
                    ref_word <= i_data;
                    pcnt     <= '0;
                end else if (state == LOCKED) begin
                    if (lock_loss) begin
                        pcnt <= '0;
                    end else if (match && i_data == ref_word && pcnt != CNT_MAX) begin
                        o_period     <= pcnt + 1'b1;
                        o_period_vld <= 1'b1;
                        pcnt         <= '0;
                    end else if (pcnt != CNT_MAX) begin
                        pcnt <= pcnt + 1'b1;
                    end
                    o_err <= !match;
                    if (!match && o_err_cnt != CNT_MAX)
                        o_err_cnt <= o_err_cnt + 1'b1;
                    if (o_word_cnt != CNT_MAX)
                        o_word_cnt <= o_word_cnt + 1'b1;
                end
            end
            if (i_clr) begin
                o_err_cnt    <= '0;
                o_word_cnt   <= '0;
                o_period     <= '0;
                o_period_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: hand-derived vector table, directed corner sequences
// and randomized traffic compared against a word-level behavioural model.
module tb_lfsr_checker;
    import lfsr_pkg::*;

    localparam int          W        = 8;
    localparam logic [7:0]  TAPS     = 8'hB8;
    localparam int          INVERT   = 1;
    localparam int          FB_DELAY = 0;
    localparam int          LOCK_CNT = 4;
    localparam int          LOSS_CNT = 3;
    localparam int          CW       = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_clr = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic          o_locked, o_err, o_period_vld;
    logic [CW-1:0] o_err_cnt, o_word_cnt, o_period;

    lfsr_checker #(
        .W(W), .TAPS(TAPS), .INVERT(1'b1), .FB_DELAY(1'b0),
        .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_clr(i_clr),
        .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt), .o_word_cnt(o_word_cnt),
        .o_period(o_period), .o_period_vld(o_period_vld)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: word history queue, lock tracked as run lengths, period as word distance.
    logic [7:0] m_hist[$];
    bit         m_locked, m_err, m_pvld;
    int         m_run, m_miss, m_err_cnt, m_word_cnt, m_period, m_since;
    logic [7:0] m_ref;
    logic [7:0] gen_state;

    typedef struct {
        bit         valid;
        logic [7:0] data;
        bit         clr;
        bit         exp_locked;
        int         exp_word_cnt;
        int         exp_err_cnt;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [7:0] gen_next(input logic [7:0] s);
        return {s[6:0], 1'(($countones(s & TAPS) + INVERT) % 2)};
    endfunction

    task automatic modelReset();
        m_hist.delete();
        m_locked = 0; m_err = 0; m_pvld = 0;
        m_run = 0; m_miss = 0; m_err_cnt = 0; m_word_cnt = 0; m_period = 0; m_since = 0;
        m_ref = '0;
    endtask

    task automatic modelStep(input bit v, input logic [7:0] d, input bit c);
        logic [7:0] src, pred;
        bit ok;
        m_err  = 0;
        m_pvld = 0;
        if (v) begin
            ok = 0;
            if (m_hist.size() >= 1 + FB_DELAY) begin
                if (FB_DELAY != 0) src = m_hist[m_hist.size()-2];
                else               src = m_hist[m_hist.size()-1];
                pred = {m_hist[m_hist.size()-1][6:0], 1'(($countones(src & TAPS) + INVERT) % 2)};
                ok = (d == pred) && (d != lockup_word(1'b1));
            end
            if (!m_locked) begin
                m_run = ok ? m_run + 1 : 0;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1; m_run = 0; m_miss = 0; m_ref = d; m_since = 0;
                end
            end else begin
                m_word_cnt++;
                m_since++;
                if (!ok) begin
                    m_err = 1;
                    m_err_cnt++;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_locked = 0; m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                    if (d == m_ref) begin
                        m_period = m_since; m_pvld = 1; m_since = 0;
                    end
                end
            end
            m_hist.push_back(d);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
        end
        if (c) begin
            m_err_cnt = 0; m_word_cnt = 0; m_period = 0; m_pvld = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".locked"},     32'(o_locked),     32'(m_locked));
        check({tag, ".err"},        32'(o_err),        32'(m_err));
        check({tag, ".err_cnt"},    32'(o_err_cnt),    32'(m_err_cnt));
        check({tag, ".word_cnt"},   32'(o_word_cnt),   32'(m_word_cnt));
        check({tag, ".period"},     32'(o_period),     32'(m_period));
        check({tag, ".period_vld"}, 32'(o_period_vld), 32'(m_pvld));
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit c, input string tag);
        @(negedge clk);
        i_valid = v; i_data = d; i_clr = c;
        @(posedge clk);
        #1;
        modelStep(v, d, c);
        checkOutput(tag);
    endtask

    task automatic sendGen(input string tag);
        applyStimulus(1'b1, gen_state, 1'b0, tag);
        gen_state = gen_next(gen_state);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; i_valid = 1'b1; i_data = 8'($urandom); i_clr = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        checkOutput(tag);
        rst_n = 1'b1;
    endtask

    task automatic runTable(input string tag);
        gen_state = 8'h00;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].data, tbl[i].clr, tag);
            check({tag, ".tbl_locked"}, 32'(o_locked), 32'(tbl[i].exp_locked));
            check({tag, ".tbl_word"},   32'(o_word_cnt), 32'(tbl[i].exp_word_cnt));
            check({tag, ".tbl_err"},    32'(o_err_cnt), 32'(tbl[i].exp_err_cnt));
            gen_state = gen_next(gen_state);
        end
    endtask

    initial begin
        int widx, cycles, gap;
        int vld_idx[$];
        bit v;
        logic [7:0] d;

        // Generator from seed 00: lock declared on the 5th word (4 matches), counting starts after.
        tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b1, 8'h01, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b1, 8'h03, 1'b0, 1'b0, 0, 0};
        tbl[3] = '{1'b1, 8'h07, 1'b0, 1'b0, 0, 0};
        tbl[4] = '{1'b1, 8'h0F, 1'b0, 1'b1, 0, 0};
        tbl[5] = '{1'b1, 8'h1E, 1'b0, 1'b1, 1, 0};
        tbl[6] = '{1'b1, 8'h3D, 1'b0, 1'b1, 2, 0};
        tbl[7] = '{1'b1, 8'h7A, 1'b0, 1'b1, 3, 0};

        modelReset();
        doReset("reset");
        doReset("reset2");

        runTable("lock");

        widx = 8;
        while (widx < 600) begin
            sendGen("run600");
            if (o_period_vld) vld_idx.push_back(widx);
            widx++;
        end
        gap = (vld_idx.size() >= 2) ? vld_idx[1] - vld_idx[0] : -1;
        check("run600.vld_count", 32'(vld_idx.size()), 32'd2);
        check("run600.vld_gap", 32'(gap), 32'd255);
        check("run600.period", 32'(o_period), 32'd255);
        check("run600.word_cnt", 32'(o_word_cnt), 32'd595);
        check("run600.err_cnt", 32'(o_err_cnt), 32'd0);

        applyStimulus(1'b1, gen_state ^ 8'h01, 1'b0, "flip");
        check("flip.err_pulse", 32'(o_err), 32'd1);
        gen_state = gen_next(gen_state);
        for (int i = 0; i < 6; i++) sendGen("flip_after");
        check("flip.err_cnt", 32'(o_err_cnt), 32'd2);
        check("flip.locked", 32'(o_locked), 32'd1);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hFF, 1'b0, "lockup");
        check("lockup.err_cnt", 32'(o_err_cnt), 32'd5);
        check("lockup.unlocked", 32'(o_locked), 32'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'hFF, 1'b0, "lockup_hold");
        check("lockup.never_relock", 32'(o_locked), 32'd0);
        for (int i = 0; i < 20; i++) sendGen("relock");
        check("relock.locked", 32'(o_locked), 32'd1);

        doReset("gaps_reset");
        gen_state = 8'h00;
        vld_idx.delete();
        widx = 0;
        cycles = 0;
        while (widx < 600 && cycles < 5000) begin
            v = 1'($urandom % 2);
            if (v) begin
                sendGen("gaps");
                if (o_period_vld) vld_idx.push_back(widx);
                widx++;
            end else begin
                applyStimulus(1'b0, 8'($urandom), 1'b0, "gaps_idle");
            end
            cycles++;
        end
        check("gaps.words_sent", 32'(widx), 32'd600);
        gap = (vld_idx.size() >= 2) ? vld_idx[1] - vld_idx[0] : -1;
        check("gaps.vld_count", 32'(vld_idx.size()), 32'd2);
        check("gaps.vld_gap", 32'(gap), 32'd255);
        check("gaps.period", 32'(o_period), 32'd255);
        check("gaps.word_cnt", 32'(o_word_cnt), 32'd595);
        check("gaps.err_cnt", 32'(o_err_cnt), 32'd0);

        applyStimulus(1'b1, gen_state ^ 8'h01, 1'b1, "clr_err");
        gen_state = gen_next(gen_state);
        check("clr_err.err_cnt", 32'(o_err_cnt), 32'd0);
        check("clr_err.err_pulse", 32'(o_err), 32'd1);
        check("clr_err.word_cnt", 32'(o_word_cnt), 32'd0);
        for (int i = 0; i < 4; i++) sendGen("clr_after");
        check("clr_after.err_cnt", 32'(o_err_cnt), 32'd1);

        for (int i = 0; i < 600; i++) begin
            v = 1'($urandom % 2);
            if (v) begin
                case ($urandom % 16)
                    0:       d = 8'($urandom);
                    1:       d = gen_state ^ (8'h01 << ($urandom % 8));
                    default: d = gen_state;
                endcase
                applyStimulus(1'b1, d, ($urandom % 40) == 0, "stress");
                gen_state = gen_next(gen_state);
            end else begin
                applyStimulus(1'b0, 8'($urandom), 1'b0, "stress_idle");
            end
        end

        for (int i = 0; i < 12; i++) sendGen("prereset");
        check("prereset.locked", 32'(o_locked), 32'd1);
        doReset("midreset");
        check("midreset.locked", 32'(o_locked), 32'd0);
        check("midreset.word_cnt", 32'(o_word_cnt), 32'd0);
        runTable("relock_tbl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
